// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg
// Shared definitions for the mem_reader block: FSM state encoding and the
// default values of the block parameters.
//
// Contents:
//   state_t            controller states (IDLE/ISSUE/DRAIN/DONE)
//   DEF_ADDR_BITS      default word-address width
//   DEF_DATA_BITS      default memory word width
//   DEF_READ_LATENCY   default slave read latency (1 or 2 cycles)
//   DEF_BUF_DEPTH      default output buffer depth (power of 2, >= latency+1)

package mem_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_BITS    = 10;
  localparam int DEF_DATA_BITS    = 32;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_BUF_DEPTH    = 4;

endpackage

// File: rtl/mem_reader_fifo.sv
// mem_reader_fifo
// Synchronous show-ahead FIFO used as the mem_reader output buffer. The head
// word is presented on pop_data whenever the FIFO is not empty, so it stays
// stable until popped. A push into a full FIFO is accepted when a pop occurs
// in the same cycle (occupancy unchanged).
//
// Ports:
//   clk        clock, posedge
//   rst        synchronous active-high reset (empties the FIFO)
//   push       write push_data
//   push_data  word to write
//   pop        remove the head word (ignored when empty)
//   pop_data   head word
//   full       DEPTH words stored
//   empty      no words stored
//   count      number of stored words, 0..DEPTH

module mem_reader_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_reader.sv
// mem_reader
// Reads a block of `length` consecutive words starting at `base_addr` from a
// fixed-latency memory slave and streams them out with valid/ready handshake.
// Reads are only issued while the words in flight plus the words already
// buffered leave room in the output buffer, so back-pressure never drops data.
//
// State table:
//   state    | meaning
//   IDLE     | waiting for start; only state that accepts a command
//   ISSUE    | issuing reads base_addr+i, at most one per cycle
//   DRAIN    | all reads issued; streaming remaining words until out_last
//   DONE     | done pulse for one cycle, then back to IDLE
//
// Ports:
//   clk, rst                      clock (posedge) and synchronous active-high reset
//   start, base_addr, length      command strobe and its arguments
//   busy, done                    command status
//   mem_address ... mem_readdata  memory slave (read-only use)
//   out_data, out_valid,
//   out_ready, out_last           output word stream

module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic [ADDR_BITS:0]     length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_BITS-1:0]   mem_address,
  output logic                   mem_chipselect,
  output logic                   mem_clken,
  output logic                   mem_write,
  output logic [DATA_BITS/8-1:0] mem_byteenable,
  input  logic [DATA_BITS-1:0]   mem_readdata,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int FCNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int OCC_W  = FCNT_W + 1;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cs;
  logic                   r_cs_last;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [ADDR_BITS-1:0]   r_base;
  logic [ADDR_BITS:0]     r_len;
  logic [ADDR_BITS:0]     r_idx;

  // One bit per outstanding read cycle; bit READ_LATENCY-1 marks the cycle in
  // which mem_readdata carries the word for that read.
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_vld_last;

  logic [ADDR_BITS:0]     w_idx_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue;
  logic [DATA_BITS:0]     w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [FCNT_W-1:0]      w_count;
  logic [OCC_W-1:0]       w_occ;

  assign mem_write      = 1'b0;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = '1;
  assign mem_chipselect = r_cs;
  assign mem_address    = r_addr;
  assign busy           = r_busy;
  assign done           = r_done;

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head[DATA_BITS-1:0];
  assign out_last  = !w_empty && w_head[DATA_BITS];

  assign w_pop      = out_valid && out_ready;
  assign w_push     = r_vld[READ_LATENCY-1];
  assign w_idx_next = r_idx + (ADDR_BITS+1)'(1);

  // Slots already claimed: the read on the bus now, reads still in the latency
  // pipe and buffered words. A word popped this cycle frees its slot now, which
  // keeps one word per cycle flowing when READ_LATENCY is 2.
  always_comb begin
    w_occ = {{(OCC_W-1){1'b0}}, r_cs};
    for (int k = 0; k < READ_LATENCY; k++) begin
      w_occ = w_occ + {{(OCC_W-1){1'b0}}, r_vld[k]};
    end
    w_occ = w_occ + {1'b0, w_count} - {{(OCC_W-1){1'b0}}, w_pop};
  end

  assign w_issue = (r_state == ST_ISSUE) && (w_occ < OCC_W'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= 1'b0;
      r_cs_last <= 1'b0;
      r_addr    <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cs      <= 1'b0;
      r_cs_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base <= base_addr;
            r_len  <= length;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_cs      <= 1'b1;
            // Truncation to ADDR_BITS gives the modulo-2^ADDR_BITS wrap.
            r_addr    <= r_base + r_idx[ADDR_BITS-1:0];
            r_cs_last <= (w_idx_next == r_len);
            r_idx     <= w_idx_next;
            if (w_idx_next == r_len) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && out_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Clearing the pipe on reset makes any data returning for reads issued
  // before reset fall on the floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_vld_last <= '0;
    end else begin
      r_vld[0]      <= r_cs;
      r_vld_last[0] <= r_cs_last;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k]      <= r_vld[k-1];
        r_vld_last[k] <= r_vld_last[k-1];
      end
    end
  end

  mem_reader_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_vld_last[READ_LATENCY-1], mem_readdata}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule

// File: tb/tb_mem_reader.sv
// Bench for mem_reader: two instances (READ_LATENCY 1 and 2) share stimulus;
// `sel` chooses which one is observed. Memory model returns mem[a] = a.
module tb_mem_reader;

  localparam int AB = 10;
  localparam int DB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_s;
  logic [AB-1:0] base_s;
  logic [AB:0]   len_s;
  logic          ready_s;
  logic          sel;

  logic          busy1, done1, cs1, clken1, wr1, valid1, last1;
  logic [AB-1:0] addr1;
  logic [3:0]    be1;
  logic [DB-1:0] rdata1, data1;
  logic          busy2, done2, cs2, clken2, wr2, valid2, last2;
  logic [AB-1:0] addr2;
  logic [3:0]    be2;
  logic [DB-1:0] rdata2, data2;

  mem_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(1), .BUF_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s), .base_addr(base_s), .length(len_s),
    .busy(busy1), .done(done1), .mem_address(addr1), .mem_chipselect(cs1),
    .mem_clken(clken1), .mem_write(wr1), .mem_byteenable(be1), .mem_readdata(rdata1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready_s), .out_last(last1));

  mem_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(2), .BUF_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s), .base_addr(base_s), .length(len_s),
    .busy(busy2), .done(done2), .mem_address(addr2), .mem_chipselect(cs2),
    .mem_clken(clken2), .mem_write(wr2), .mem_byteenable(be2), .mem_readdata(rdata2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready_s), .out_last(last2));

  // Memory slaves: data valid READ_LATENCY cycles after the chipselect cycle,
  // garbage otherwise so mistimed captures show up.
  logic          m1_cs, m2_cs_a, m2_cs_b;
  logic [AB-1:0] m1_a, m2_a_a, m2_a_b;
  always @(posedge clk) begin
    m1_cs   <= cs1;   m1_a   <= addr1;
    m2_cs_a <= cs2;   m2_a_a <= addr2;
    m2_cs_b <= m2_cs_a; m2_a_b <= m2_a_a;
  end
  assign rdata1 = m1_cs   ? {22'd0, m1_a}   : 32'hDEAD_BEEF;
  assign rdata2 = m2_cs_b ? {22'd0, m2_a_b} : 32'hDEAD_BEEF;

  logic          cs_v, valid_v, last_v, busy_v, done_v;
  logic [AB-1:0] addr_v;
  logic [DB-1:0] data_v;
  assign cs_v    = sel ? cs2    : cs1;
  assign addr_v  = sel ? addr2  : addr1;
  assign valid_v = sel ? valid2 : valid1;
  assign data_v  = sel ? data2  : data1;
  assign last_v  = sel ? last2  : last1;
  assign busy_v  = sel ? busy2  : busy1;
  assign done_v  = sel ? done2  : done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued, consumed, done_cnt, done_cyc, start_cyc;
  logic [DB-1:0] obs_data[$];
  logic [AB-1:0] obs_addr[$];
  bit            obs_last[$];
  int            obs_cyc[$];

  typedef struct {
    int base;
    int len;
    int exp_n;
    int exp_first;
    int exp_lastw;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Observe the current cycle (ready_s already set for it), then advance.
  task automatic tick();
    if (cs_v) begin
      obs_addr.push_back(addr_v);
      issued++;
    end
    checks++;
    if (issued - consumed > 4) begin
      errors++;
      $display("FAIL buf_bound: outstanding %0d expected <= 4 (cycle %0d)", issued - consumed, cyc);
    end
    if (valid_v && ready_s) begin
      obs_data.push_back(data_v);
      obs_last.push_back(last_v);
      obs_cyc.push_back(cyc);
      consumed++;
    end
    if (done_v) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_addr.delete(); obs_last.delete(); obs_cyc.delete();
    issued = 0; consumed = 0; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic run_cmd(input int base, input int len, input bit rnd, input int mid_start);
    clear_obs();
    chk("idle_busy", busy_v, 1'b0);
    base_s = AB'(base); len_s = (AB+1)'(len); start_s = 1'b1;
    ready_s = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    start_cyc = cyc;
    tick();
    start_s = 1'b0;
    base_s = AB'($urandom); len_s = (AB+1)'($urandom);
    chk("busy_after_start", busy_v, 1'b1);
    for (int k = 1; k < 600 && done_cnt == 0; k++) begin
      if (k == mid_start) begin
        start_s = 1'b1; base_s = AB'(500); len_s = (AB+1)'(4);
      end
      ready_s = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      start_s = 1'b0;
    end
    chk("done_seen", (done_cnt == 0) ? 1'b0 : 1'b1, 1'b1);
    chk("done_pulse_width", done_v, 1'b0);
    ready_s = 1'b1;
  endtask

  // Reference: len words, word i = (base + i) mod 2^AB, last on the final one.
  task automatic check_stream(input int base, input int len, input bit all_ready);
    int n;
    int exp;
    chk("n_words", obs_data.size(), len);
    chk("n_reads", obs_addr.size(), len);
    n = (obs_data.size() < len) ? obs_data.size() : len;
    for (int i = 0; i < n; i++) begin
      exp = (base + i) % (1 << AB);
      chk("data", obs_data[i], exp);
      chk("last", obs_last[i], (i == len - 1) ? 1'b1 : 1'b0);
    end
    n = (obs_addr.size() < len) ? obs_addr.size() : len;
    for (int i = 0; i < n; i++) chk("addr", obs_addr[i], (base + i) % (1 << AB));
    if (len == 0) begin
      chk("done_lat_len0", done_cyc - start_cyc, 1);
    end else if (obs_cyc.size() == len) begin
      chk("done_after_last", done_cyc - obs_cyc[len-1], 1);
      if (all_ready)
        for (int i = 1; i < len; i++) chk("back_to_back", obs_cyc[i] - obs_cyc[i-1], 1);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy_v, 1'b0);
    chk("rst_done", done_v, 1'b0);
    chk("rst_valid", valid_v, 1'b0);
    chk("rst_last", last_v, 1'b0);
    chk("rst_data", data_v, 0);
    chk("rst_cs", cs_v, 1'b0);
    chk("rst_addr", addr_v, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l;
    vt[0] = '{0,    8,  8, 0,    7};
    vt[1] = '{1020, 8,  8, 1020, 3};
    vt[2] = '{1023, 1,  1, 1023, 1023};
    vt[3] = '{5,    3,  3, 5,    7};
    vt[4] = '{1000, 0,  0, 0,    0};
    vt[5] = '{2,    20, 20, 2,   21};

    sel = 1'b0; start_s = 1'b0; base_s = '0; len_s = '0; ready_s = 1'b1; rst = 1'b0;
    #1;
    do_reset();
    check_reset_vals();
    chk("tie_write1", wr1, 1'b0);
    chk("tie_clken1", clken1, 1'b1);
    chk("tie_be1", be1, 4'hF);
    chk("tie_write2", wr2, 1'b0);
    chk("tie_be2", be2, 4'hF);

    // Back-to-back commands: each start lands the cycle after the previous done.
    for (int t = 0; t < 6; t++) begin
      run_cmd(vt[t].base, vt[t].len, 1'b0, -1);
      chk("tbl_count", obs_data.size(), vt[t].exp_n);
      if (vt[t].exp_n > 0 && obs_data.size() > 0) begin
        chk("tbl_first", obs_data[0], vt[t].exp_first);
        chk("tbl_lastw", obs_data[obs_data.size()-1], vt[t].exp_lastw);
      end
      check_stream(vt[t].base, vt[t].len, 1'b1);
    end

    // Start pulsed mid-transfer must be ignored.
    run_cmd(0, 8, 1'b0, 3);
    check_stream(0, 8, 1'b1);

    // Reset three cycles into a 16-word read, then a fresh 2-word command.
    clear_obs();
    base_s = '0; len_s = (AB+1)'(16); start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals();
    run_cmd(100, 2, 1'b0, -1);
    check_stream(100, 2, 1'b1);

    // Random back-pressure on the latency-2 instance.
    sel = 1'b1;
    do_reset();
    check_reset_vals();
    b = $urandom_range(0, 1023);
    run_cmd(b, 32, 1'b1, -1);
    check_stream(b, 32, 1'b0);
    for (int r = 0; r < 4; r++) begin
      b = $urandom_range(0, 1023);
      l = $urandom_range(0, 40);
      run_cmd(b, l, 1'b1, -1);
      check_stream(b, l, 1'b0);
    end

    // Random commands on the latency-1 instance.
    sel = 1'b0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      b = $urandom_range(0, 1023);
      l = $urandom_range(1, 40);
      run_cmd(b, l, 1'b1, -1);
      check_stream(b, l, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
